trena_multicanal: RTL
=====================

Name: trena_multicanal

Overview:
- N-channel ultrasonic ranging controller for HC-SR04-class sensors.
- On one measurement request it triggers each channel in turn and times that channel's echo pulse.
- Each echo width is converted to rounded centimetres; a per-channel timeout/error flag is kept.
- Sits between the sensor pins and the display/serial-transmit logic. Adds to the single-channel trena: channel count, width, rounding, timeout and continuous mode.

Parameters:
- N_CANAIS, 4, number of sensor channels (1..8).
- LARGURA, 12, width of each distance result in cm.
- CICLOS_TRIGGER, 500, trigger high time in clock cycles (10 us at 50 MHz).
- CICLOS_CM, 2941, clock cycles per cm of range (58.82 us at 50 MHz).
- MAX_CM, 400, saturation/error threshold in cm.
- TIMEOUT_CICLOS, 1_500_000, max cycles from trigger fall to echo fall (30 ms).
- INTERVALO_CICLOS, 3_000_000, idle gap between scans in continuous mode (60 ms).

Ports:
- clock, input, 1, system clock (50 MHz).
- reset, input, 1, asynchronous, active-low reset (0 = reset).
- mensurar, input, 1, start request; the rising edge is detected internally.
- continuo, input, 1, 1 = rescan automatically after each scan.
- echo, input, N_CANAIS, asynchronous echo inputs, one per sensor.
- trigger, output, N_CANAIS, trigger outputs; at most one bit is high at a time.
- medida, output, N_CANAIS*LARGURA, packed results; channel k occupies bits [k*LARGURA +: LARGURA].
- erro, output, N_CANAIS, per-channel error flag from the last scan.
- pronto, output, 1, one-cycle pulse when a scan completes.
- ocupado, output, 1, high from scan start until the pronto cycle.
- db_estado, output, 4, current FSM state code.
- db_canal, output, 3, index of the channel being serviced.

Behaviour:
- Reset (reset=0, asynchronous) forces all outputs and registers to 0:
  - trigger, medida, erro, pronto and ocupado are 0; FSM goes to INICIAL.
  - Taking effect mid-scan aborts the scan with no pronto.
- Each echo bit passes through a 2-FF synchronizer. Both edges are delayed equally, so measured width is unaffected.
- Start: a mensurar 0->1 edge in INICIAL starts a scan. An edge arriving while ocupado=1 is ignored, not queued.
- FSM states and codes:
  - INICIAL 0: idle.
  - PREPARA 1: clear cycle/cm counters; load db_canal.
  - TRIGGER 2: trigger[canal]=1 for exactly CICLOS_TRIGGER cycles.
  - ESPERA_ECHO 3: wait for synchronized echo rise.
  - MEDE 4: counting while echo is high.
  - ARMAZENA 5: write medida/erro for the channel.
  - PROXIMO 6: canal+1; go to PREPARA, or to FINAL after the last channel.
  - FINAL 7: pronto=1 for one cycle.
  - INTERVALO 8: continuous-mode wait.
- After FINAL:
  - continuo=1: go to INTERVALO for INTERVALO_CICLOS cycles, then PREPARA with canal=0.
  - continuo=0: go to INICIAL.
  - continuo is sampled at FINAL.
- Rounding conversion:
  - In MEDE the tick counter starts at CICLOS_CM/2 (integer division, 1470).
  - It increments each echo-high cycle; on reaching CICLOS_CM-1 it wraps to 0 and the cm counter increments.
  - Result: cm = floor((n + CICLOS_CM/2) / CICLOS_CM), i.e. round-half-up, where n = echo-high cycles.
- Timeout: a single counter runs from the end of TRIGGER. If it reaches TIMEOUT_CICLOS in ESPERA_ECHO or MEDE:
  - go to ARMAZENA with erro[canal]=1 and medida[canal]=0;
  - the scan continues with the next channel.
- Saturation: if the cm counter reaches MAX_CM, go to ARMAZENA immediately with erro[canal]=1 and medida[canal]=MAX_CM. The rest of the echo is ignored.
- Valid measurement: erro[canal]=0 and medida[canal]=cm.
- Register behaviour: medida/erro for a channel update only in that channel's ARMAZENA cycle. Other channels hold their previous values.
- An echo already high on entry to ESPERA_ECHO counts as a rise only after it has been seen low. Before that it is treated as stuck and is covered by the timeout.
- All counters are sized from their parameters (clog2); no wrap-around is reachable before the timeout fires.

Test Plan:
- Echo widths 5882 us, 5899 us, 4353 us, 4399 us on channels 0..3, each rising 400 us after its trigger falls -> medida = 100, 100, 74, 75; erro=0000; one pronto pulse.
- Trigger check -> each trigger[k] is high exactly 500 cycles, channels fire strictly in order 0..3, and no two trigger bits overlap.
- Channel 2 echo never rises -> erro=0100, medida[2]=0, pronto asserts ~30 ms after trigger[2] falls, and channels 0/1/3 are measured correctly.
- Channel 1 echo 25 ms wide -> erro[1]=1, medida[1]=400, and scanning continues to channel 2.
- continuo=1 with a single mensurar pulse -> repeated pronto pulses ~60 ms plus measurement time apart. Dropping continuo -> FSM returns to INICIAL after the next pronto. A mensurar pulse mid-scan -> no extra scan.
- reset=0 asserted during MEDE on channel 1 -> trigger, medida, erro, pronto and ocupado are 0 immediately, with no pronto. After release, a new mensurar runs a clean full scan.

Source files
------------

// File: rtl/trena_multicanal.sv
// N-channel ultrasonic ranging controller: triggers each sensor in turn,
// times its echo and stores rounded centimetres plus a per-channel error flag.
module trena_multicanal #(
  parameter int N_CANAIS         = 4,
  parameter int LARGURA          = 12,
  parameter int CICLOS_TRIGGER   = 500,
  parameter int CICLOS_CM        = 2941,
  parameter int MAX_CM           = 400,
  parameter int TIMEOUT_CICLOS   = 1_500_000,
  parameter int INTERVALO_CICLOS = 3_000_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          mensurar,
  input  logic                          continuo,
  input  logic [N_CANAIS-1:0]           echo,
  output logic [N_CANAIS-1:0]           trigger,
  output logic [N_CANAIS*LARGURA-1:0]   medida,
  output logic [N_CANAIS-1:0]           erro,
  output logic                          pronto,
  output logic                          ocupado,
  output logic [3:0]                    db_estado,
  output logic [2:0]                    db_canal
);

  localparam int CNT_MAX = (CICLOS_TRIGGER > INTERVALO_CICLOS) ? CICLOS_TRIGGER : INTERVALO_CICLOS;
  localparam int W_CNT   = $clog2(CNT_MAX + 1);
  localparam int W_TICK  = $clog2(CICLOS_CM);
  localparam int W_CM    = $clog2(MAX_CM + 1);
  localparam int W_TO    = $clog2(TIMEOUT_CICLOS + 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    TRIGGER     = 4'd2,
    ESPERA_ECHO = 4'd3,
    MEDE        = 4'd4,
    ARMAZENA    = 4'd5,
    PROXIMO     = 4'd6,
    FINAL       = 4'd7,
    INTERVALO   = 4'd8
  } estado_t;

  estado_t             estado, prox;
  logic [N_CANAIS-1:0] echo_m, echo_s;
  logic [2:0]          mens_sr;
  logic [W_CNT-1:0]    cnt;
  logic [W_TO-1:0]     to_cnt;
  logic [W_TICK-1:0]   tick;
  logic [W_CM-1:0]     cm;
  logic [2:0]          canal;
  logic                visto_baixo;
  logic                estouro;

  logic inicio_pedido, echo_sel, subida, sat, tmo, fim_trig, fim_int, ultimo, conta;

  // Echo bits and the start request share the same two-stage synchronizer depth
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_m  <= '0;
      echo_s  <= '0;
      mens_sr <= '0;
    end else begin
      echo_m  <= echo;
      echo_s  <= echo_m;
      mens_sr <= {mens_sr[1:0], mensurar};
    end
  end

  always_comb begin
    echo_sel = 1'b0;
    for (int unsigned k = 0; k < N_CANAIS; k++) begin
      if (canal == 3'(k)) echo_sel = echo_s[k];
    end
  end

  assign inicio_pedido = mens_sr[1] & ~mens_sr[2];
  // A level already high on entry only counts once it has been seen low
  assign subida   = echo_sel & visto_baixo;
  assign sat      = (cm == W_CM'(MAX_CM));
  assign tmo      = (to_cnt == W_TO'(TIMEOUT_CICLOS - 1));
  assign fim_trig = (cnt == W_CNT'(CICLOS_TRIGGER - 1));
  assign fim_int  = (cnt == W_CNT'(INTERVALO_CICLOS - 1));
  assign ultimo   = (canal == 3'(N_CANAIS - 1));
  // The rise cycle itself is counted, so every synchronized high cycle adds one tick
  assign conta    = ((estado == ESPERA_ECHO) && subida && !tmo) ||
                    ((estado == MEDE) && echo_sel && !sat && !tmo);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:     if (inicio_pedido) prox = PREPARA;
      PREPARA:     prox = TRIGGER;
      TRIGGER:     if (fim_trig) prox = ESPERA_ECHO;
      ESPERA_ECHO: if (tmo) prox = ARMAZENA;
                   else if (subida) prox = MEDE;
      MEDE:        if (sat || tmo || !echo_sel) prox = ARMAZENA;
      ARMAZENA:    prox = PROXIMO;
      PROXIMO:     prox = ultimo ? FINAL : PREPARA;
      FINAL:       prox = continuo ? INTERVALO : INICIAL;
      INTERVALO:   if (fim_int) prox = PREPARA;
      default:     prox = INICIAL;
    endcase
  end

  always_comb begin
    trigger = '0;
    for (int unsigned k = 0; k < N_CANAIS; k++) begin
      trigger[k] = (estado == TRIGGER) && (canal == 3'(k));
    end
    pronto    = (estado == FINAL);
    ocupado   = (estado != INICIAL) && (estado != INTERVALO);
    db_estado = estado;
    db_canal  = canal;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      to_cnt      <= '0;
      tick        <= '0;
      cm          <= '0;
      canal       <= '0;
      visto_baixo <= 1'b0;
      estouro     <= 1'b0;
      medida      <= '0;
      erro        <= '0;
    end else begin
      if (estado == TRIGGER || estado == INTERVALO) cnt <= cnt + 1'b1;
      else                                          cnt <= '0;

      if (estado == ESPERA_ECHO || estado == MEDE) to_cnt <= to_cnt + 1'b1;
      else                                         to_cnt <= '0;

      if (estado == PREPARA) begin
        // Starting at half a centimetre turns the truncating divide into round-half-up
        tick        <= W_TICK'(CICLOS_CM / 2);
        cm          <= '0;
        visto_baixo <= 1'b0;
        estouro     <= 1'b0;
      end else begin
        if (conta) begin
          if (tick == W_TICK'(CICLOS_CM - 1)) begin
            tick <= '0;
            cm   <= cm + 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        if (estado == ESPERA_ECHO && !echo_sel) visto_baixo <= 1'b1;
        if ((estado == ESPERA_ECHO && tmo) || (estado == MEDE && !sat && tmo)) estouro <= 1'b1;
      end

      if ((estado == INICIAL && inicio_pedido) || (estado == INTERVALO && fim_int)) canal <= '0;
      else if (estado == PROXIMO && !ultimo) canal <= canal + 1'b1;

      if (estado == ARMAZENA) begin
        for (int unsigned k = 0; k < N_CANAIS; k++) begin
          if (canal == 3'(k)) begin
            erro[k] <= estouro | sat;
            if (estouro)  medida[k*LARGURA +: LARGURA] <= '0;
            else if (sat) medida[k*LARGURA +: LARGURA] <= LARGURA'(MAX_CM);
            else          medida[k*LARGURA +: LARGURA] <= LARGURA'(cm);
          end
        end
      end
    end
  end

endmodule
